// File: rtl/bcd7seg_rom.sv
`default_nettype none
// ============================================================================
// Module      : bcd7seg_rom
// Description : PS/2 set-2 scan-code display stage. Captures scan codes,
//               translates them to ASCII through a fixed ROM and drives six
//               active-low hex 7-segment digits (scan code, ASCII, release
//               counter).
// Config      : KEY_COUNT_EN - when defined, a break-prefix (0xF0) counter
//               drives key_count and seg4/seg5; when undefined, key_count is
//               tied to zero and seg4/seg5 are blank.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd7seg_rom (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] code_in,
    input  logic       code_valid,
    input  logic       show,
    output logic [7:0] code,
    output logic [7:0] ascii,
    output logic [7:0] key_count,
    output logic [7:0] seg0,
    output logic [7:0] seg1,
    output logic [7:0] seg2,
    output logic [7:0] seg3,
    output logic [7:0] seg4,
    output logic [7:0] seg5
);

    localparam logic [7:0] C_BREAK = 8'hF0;
    localparam logic [7:0] C_BLANK = 8'hFF;

    // Hex glyph encoder: {blank, nibble} -> active-low segments, dp always off.
    function automatic logic [7:0] seg_enc(input logic [4:0] d);
        logic [7:0] s;
        if (d[4]) begin
            s = C_BLANK;
        end else begin
            case (d[3:0])
                4'h0: s = 8'hC0;
                4'h1: s = 8'hF9;
                4'h2: s = 8'hA4;
                4'h3: s = 8'hB0;
                4'h4: s = 8'h99;
                4'h5: s = 8'h92;
                4'h6: s = 8'h82;
                4'h7: s = 8'hF8;
                4'h8: s = 8'h80;
                4'h9: s = 8'h90;
                4'hA: s = 8'h88;
                4'hB: s = 8'h83;
                4'hC: s = 8'hC6;
                4'hD: s = 8'hA1;
                4'hE: s = 8'h86;
                default: s = 8'h8E;
            endcase
        end
        return s;
    endfunction

    logic [7:0] rom_data;
    logic [7:0] code_q,  code_d;
    logic [7:0] ascii_q, ascii_d;

    // Scan-code to ASCII lookup; anything not listed reads as zero.
    always_comb begin
        rom_data = 8'h00;
        case (code_in)
            8'h1C: rom_data = 8'h61; 8'h32: rom_data = 8'h62;
            8'h21: rom_data = 8'h63; 8'h23: rom_data = 8'h64;
            8'h24: rom_data = 8'h65; 8'h2B: rom_data = 8'h66;
            8'h34: rom_data = 8'h67; 8'h33: rom_data = 8'h68;
            8'h43: rom_data = 8'h69; 8'h3B: rom_data = 8'h6A;
            8'h42: rom_data = 8'h6B; 8'h4B: rom_data = 8'h6C;
            8'h3A: rom_data = 8'h6D; 8'h31: rom_data = 8'h6E;
            8'h44: rom_data = 8'h6F; 8'h4D: rom_data = 8'h70;
            8'h15: rom_data = 8'h71; 8'h2D: rom_data = 8'h72;
            8'h1B: rom_data = 8'h73; 8'h2C: rom_data = 8'h74;
            8'h3C: rom_data = 8'h75; 8'h2A: rom_data = 8'h76;
            8'h1D: rom_data = 8'h77; 8'h22: rom_data = 8'h78;
            8'h35: rom_data = 8'h79; 8'h1A: rom_data = 8'h7A;
            8'h45: rom_data = 8'h30; 8'h16: rom_data = 8'h31;
            8'h1E: rom_data = 8'h32; 8'h26: rom_data = 8'h33;
            8'h25: rom_data = 8'h34; 8'h2E: rom_data = 8'h35;
            8'h36: rom_data = 8'h36; 8'h3D: rom_data = 8'h37;
            8'h3E: rom_data = 8'h38; 8'h46: rom_data = 8'h39;
            8'h29: rom_data = 8'h20; 8'h5A: rom_data = 8'h0D;
            8'h66: rom_data = 8'h08;
            default: rom_data = 8'h00;
        endcase
    end

    // Capture the new scan code and its ASCII only on a strobe, else hold.
    always_comb begin
        code_d  = code_q;
        ascii_d = ascii_q;
        if (code_valid) begin
            code_d  = code_in;
            ascii_d = rom_data;
        end
    end

    // Code/ASCII registers; reset wins over a coincident strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q  <= 8'h00;
            ascii_q <= 8'h00;
        end else begin
            code_q  <= code_d;
            ascii_q <= ascii_d;
        end
    end

    assign code  = code_q;
    assign ascii = ascii_q;

    // Scan-code and ASCII digits blank while the receiver is not ready.
    assign seg0 = seg_enc({~show, code_q[3:0]});
    assign seg1 = seg_enc({~show, code_q[7:4]});
    assign seg2 = seg_enc({~show, ascii_q[3:0]});
    assign seg3 = seg_enc({~show, ascii_q[7:4]});

`ifdef KEY_COUNT_EN
    logic [7:0] count_q, count_d;

    // Count break prefixes; natural 8-bit wrap from FF to 00.
    always_comb begin
        count_d = count_q;
        if (code_valid && (code_in == C_BREAK)) begin
            count_d = count_q + 8'd1;
        end
    end

    // Break counter register; reset discards a coincident strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 8'h00;
        end else begin
            count_q <= count_d;
        end
    end

    assign key_count = count_q;
    assign seg4      = seg_enc({1'b0, count_q[3:0]});
    assign seg5      = seg_enc({1'b0, count_q[7:4]});
`else
    assign key_count = 8'h00;
    assign seg4      = C_BLANK;
    assign seg5      = C_BLANK;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bcd7seg_rom.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd7seg_rom
// Description : Scoreboard bench for bcd7seg_rom. Stimulus pushes the
//               expected post-edge state; a monitor pops and compares it
//               after each rising edge. Honours KEY_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd7seg_rom;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] code_in = 8'h00;
    logic       code_valid = 1'b0;
    logic       show = 1'b1;
    logic [7:0] code, ascii, key_count;
    logic [7:0] seg0, seg1, seg2, seg3, seg4, seg5;

    bcd7seg_rom dut (
        .clk        (clk),
        .rst        (rst),
        .code_in    (code_in),
        .code_valid (code_valid),
        .show       (show),
        .code       (code),
        .ascii      (ascii),
        .key_count  (key_count),
        .seg0       (seg0),
        .seg1       (seg1),
        .seg2       (seg2),
        .seg3       (seg3),
        .seg4       (seg4),
        .seg5       (seg5)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  code;
        logic [7:0]  ascii;
        logic [7:0]  cnt;
        logic [47:0] segs;  // {seg5,seg4,seg3,seg2,seg1,seg0}
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic [7:0] m_code  = 8'h00;
    logic [7:0] m_ascii = 8'h00;
    logic [7:0] m_cnt   = 8'h00;

    function automatic logic [7:0] glyph(input logic blank, input logic [3:0] n);
        logic [7:0] tbl [16];
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return blank ? 8'hFF : tbl[n];
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; exp_a is the hand-computed ASCII of c.
    task automatic step(input logic r, input logic v, input logic [7:0] c,
                        input logic s, input logic [7:0] exp_a);
        exp_t e;
        @(negedge clk);
        rst = r; code_valid = v; code_in = c; show = s;
        if (r) begin
            m_code = 8'h00; m_ascii = 8'h00; m_cnt = 8'h00;
        end else if (v) begin
            m_code = c; m_ascii = exp_a;
            if (c == 8'hF0) m_cnt = m_cnt + 8'd1;
        end
        e.code  = m_code;
        e.ascii = m_ascii;
`ifdef KEY_COUNT_EN
        e.cnt   = m_cnt;
        e.segs[47:32] = {glyph(1'b0, m_cnt[7:4]), glyph(1'b0, m_cnt[3:0])};
`else
        e.cnt   = 8'h00;
        e.segs[47:32] = 16'hFFFF;
`endif
        e.segs[31:0] = {glyph(~s, m_ascii[7:4]), glyph(~s, m_ascii[3:0]),
                        glyph(~s, m_code[7:4]),  glyph(~s, m_code[3:0])};
        sb.push_back(e);
    endtask

    // Monitor: compare one expectation after every rising edge that has one.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("code",      code,      e.code);
                chk("ascii",     ascii,     e.ascii);
                chk("key_count", key_count, e.cnt);
                chk("seg0",      seg0,      e.segs[7:0]);
                chk("seg1",      seg1,      e.segs[15:8]);
                chk("seg2",      seg2,      e.segs[23:16]);
                chk("seg3",      seg3,      e.segs[31:24]);
                chk("seg4",      seg4,      e.segs[39:32]);
                chk("seg5",      seg5,      e.segs[47:40]);
            end
        end
    end

    typedef struct packed {
        logic [7:0] sc;
        logic [7:0] asc;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs = '{'{8'h1A, 8'h7A}, '{8'h29, 8'h20}, '{8'h5A, 8'h0D},
                 '{8'h66, 8'h08}, '{8'h46, 8'h39}, '{8'h2D, 8'h72},
                 '{8'h4D, 8'h70}, '{8'h3E, 8'h38}, '{8'hFF, 8'h00},
                 '{8'h00, 8'h00}};

        // Reset with digits shown, then blanked.
        step(1'b1, 1'b0, 8'h00, 1'b1, 8'h00);
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);

        // 'a': 1C -> 61; seg0=C6 seg1=F9 seg2=F9 seg3=82.
        step(1'b0, 1'b1, 8'h1C, 1'b1, 8'h61);
        // Hold with no strobe, then blank/unblank via show alone.
        step(1'b0, 1'b0, 8'h55, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h55, 1'b0, 8'h00);

        // '0' then unmapped 07 back-to-back; last one wins.
        step(1'b0, 1'b1, 8'h45, 1'b1, 8'h30);
        step(1'b0, 1'b1, 8'h07, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'h00);

        foreach (vecs[i]) step(1'b0, 1'b1, vecs[i].sc, 1'b1, vecs[i].asc);

        // 257 break prefixes with a hold cycle between each: count wraps to 01.
        for (int i = 0; i < 257; i++) begin
            step(1'b0, 1'b1, 8'hF0, 1'b1, 8'h00);
            step(1'b0, 1'b0, 8'hF0, 1'b1, 8'h00);
        end
        // Consecutive F0 strobes each count.
        step(1'b0, 1'b1, 8'hF0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'hF0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h2D, 1'b0, 8'h72);

        // Reset coincident with an F0 strobe: strobe discarded.
        step(1'b1, 1'b1, 8'hF0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'h00);

        repeat (3) @(negedge clk);
        code_valid = 1'b0;
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
